// File: rtl/seg7_scan_reader_if.sv
// Scanner-side bus of the 7-segment reader.
// The display driver owns SEG/AN; the reader owns the frame result signals.
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              SEG;
    logic [NUM_DIGITS-1:0]   AN;
    logic [4*NUM_DIGITS-1:0] DIGITS;
    logic [NUM_DIGITS-1:0]   INVALID;
    logic                    FRAME_VALID;
    logic                    AN_ERR;
    logic                    STALE;

    modport master (
        output SEG, AN,
        input  DIGITS, INVALID, FRAME_VALID, AN_ERR, STALE
    );

    modport slave (
        input  SEG, AN,
        output DIGITS, INVALID, FRAME_VALID, AN_ERR, STALE
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// Reader for a multiplexed active-low 7-segment display: waits for each
// segment/anode pair to settle, inverse-decodes it and assembles whole frames.
module seg7_scan_reader #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_reader_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

    typedef enum logic {SETTLE, HOLD} state_e;

    state_e                  state_q, state_d;
    logic [6:0]              seg_s1_q, seg_s2_q, seg_p_q;
    logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q, an_p_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] work_q, work_d;
    logic [NUM_DIGITS-1:0]   winv_q, winv_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   invalid_q, invalid_d;
    logic                    fv_q, fv_d;
    logic                    anerr_q, anerr_d;
    logic                    stale_q, stale_d;

    logic                    changed;
    logic                    capture;
    logic                    onehot;
    logic                    complete;
    logic [NUM_DIGITS-1:0]   an_lo;
    logic [4:0]              dec;

    // Returns {not_a_glyph, nibble}; unknown patterns decode to nibble 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h01:   seg_decode = 5'h00;
            7'h4F:   seg_decode = 5'h01;
            7'h12:   seg_decode = 5'h02;
            7'h06:   seg_decode = 5'h03;
            7'h4C:   seg_decode = 5'h04;
            7'h24:   seg_decode = 5'h05;
            7'h20:   seg_decode = 5'h06;
            7'h0F:   seg_decode = 5'h07;
            7'h00:   seg_decode = 5'h08;
            7'h04:   seg_decode = 5'h09;
            7'h08:   seg_decode = 5'h0A;
            7'h60:   seg_decode = 5'h0B;
            7'h31:   seg_decode = 5'h0C;
            7'h42:   seg_decode = 5'h0D;
            7'h30:   seg_decode = 5'h0E;
            7'h38:   seg_decode = 5'h0F;
            default: seg_decode = 5'h10;
        endcase
    endfunction

    assign changed = (seg_s2_q != seg_p_q) || (an_s2_q != an_p_q);

    always_comb begin
        if (changed)
            cnt_d = CW'(1);
        else if (cnt_q == STABLE_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= SETTLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SETTLE: if (cnt_q == STABLE_MAX && !changed) state_d = HOLD;
            HOLD:   if (changed) state_d = SETTLE;
            default: state_d = SETTLE;
        endcase
    end

    // The counted sample is the previous-sample register, so decode from it.
    always_comb begin
        capture = (state_q == SETTLE) && (cnt_q == STABLE_MAX);
    end

    always_comb begin
        an_lo  = ~an_p_q;
        onehot = (an_lo != '0) && ((an_lo & (an_lo - 1'b1)) == '0);
        dec    = seg_decode(seg_p_q);
    end

    always_comb begin
        work_d   = work_q;
        winv_d   = winv_q;
        seen_d   = seen_q;
        anerr_d  = 1'b0;
        complete = 1'b0;
        if (capture) begin
            if (!onehot) begin
                anerr_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (an_lo[i]) begin
                        work_d[4*i +: 4] = dec[3:0];
                        winv_d[i]        = dec[4];
                        seen_d[i]        = 1'b1;
                    end
                end
                if (&seen_d) begin
                    complete = 1'b1;
                    seen_d   = '0;
                end
            end
        end
        digits_d  = complete ? work_d : digits_q;
        invalid_d = complete ? winv_d : invalid_q;
        fv_d      = complete;
        if (complete)
            tmo_d = '0;
        else if (tmo_q == TMO_MAX)
            tmo_d = tmo_q;
        else
            tmo_d = tmo_q + 1'b1;
        stale_d = !complete && (stale_q || (tmo_d == TMO_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q  <= 7'h7F;
            seg_s2_q  <= 7'h7F;
            seg_p_q   <= 7'h7F;
            an_s1_q   <= '1;
            an_s2_q   <= '1;
            an_p_q    <= '1;
            cnt_q     <= '0;
            work_q    <= '0;
            winv_q    <= '0;
            seen_q    <= '0;
            tmo_q     <= '0;
            digits_q  <= '0;
            invalid_q <= '0;
            fv_q      <= 1'b0;
            anerr_q   <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            seg_s1_q  <= bus.SEG;
            seg_s2_q  <= seg_s1_q;
            seg_p_q   <= seg_s2_q;
            an_s1_q   <= bus.AN;
            an_s2_q   <= an_s1_q;
            an_p_q    <= an_s2_q;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            winv_q    <= winv_d;
            seen_q    <= seen_d;
            tmo_q     <= tmo_d;
            digits_q  <= digits_d;
            invalid_q <= invalid_d;
            fv_q      <= fv_d;
            anerr_q   <= anerr_d;
            stale_q   <= stale_d;
        end
    end

    assign bus.DIGITS      = digits_q;
    assign bus.INVALID     = invalid_q;
    assign bus.FRAME_VALID = fv_q;
    assign bus.AN_ERR      = anerr_q;
    assign bus.STALE       = stale_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader: directed scans push expected
// frames/anode errors, a negedge monitor pops and compares each event.
module tb_seg7_scan_reader;
    localparam int ND = 4;

    typedef struct packed {
        logic        err;
        logic [15:0] dig;
        logic [3:0]  inv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_reader_if #(.NUM_DIGITS(ND)) bus();

    seg7_scan_reader #(
        .NUM_DIGITS(ND),
        .STABLE_CYCLES(16),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    exp_t q[$];
    exp_t mon_got, mon_exp;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int last_fv_cyc = 0;
    int f0, chg;
    logic [6:0] pat [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every FRAME_VALID or AN_ERR cycle consumes one expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.FRAME_VALID || bus.AN_ERR)) begin
            mon_got = '{err: bus.AN_ERR, dig: bus.DIGITS, inv: bus.INVALID};
            if (bus.FRAME_VALID) begin
                fv_cnt++;
                last_fv_cyc = cyc;
            end
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got err=%0b digits=%h inv=%b, required none",
                         mon_got.err, mon_got.dig, mon_got.inv);
            end else begin
                mon_exp = q.pop_front();
                if (mon_exp.err ? (mon_got.err !== 1'b1 || bus.FRAME_VALID !== 1'b0)
                                : (mon_got !== mon_exp)) begin
                    fails++;
                    $display("FAIL scoreboard @%0d: got err=%0b digits=%h inv=%b, required err=%0b digits=%h inv=%b",
                             cyc, mon_got.err, mon_got.dig, mon_got.inv,
                             mon_exp.err, mon_exp.dig, mon_exp.inv);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.AN  = an;
        bus.SEG = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] inv);
        q.push_back('{err: 1'b0, dig: d, inv: inv});
    endtask

    task automatic push_err();
        q.push_back('{err: 1'b1, dig: 16'h0, inv: 4'h0});
    endtask

    task automatic outs_zero(input string name);
        chk(name, {12'h0, bus.DIGITS, bus.INVALID, bus.FRAME_VALID, bus.AN_ERR, bus.STALE}, 32'h0);
    endtask

    initial begin
        bus.AN  = 4'b1111;
        bus.SEG = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        outs_zero("reset_outputs");

        // Idle all-high anodes settle and are reported once as a bad anode.
        push_err();
        rst_n = 1'b1;
        dwell(4'b1111, 7'h7F, 25);

        for (int g = 0; g < 16; g++) begin
            push_frame({12'h0, 4'(g)}, 4'b0000);
            dwell(4'b1110, pat[g], 20);
            dwell(4'b1101, 7'h01, 20);
            dwell(4'b1011, 7'h01, 20);
            dwell(4'b0111, 7'h01, 20);
        end

        f0 = fv_cnt;
        push_frame(16'h4321, 4'b0000);
        dwell(4'b1110, 7'h4F, 32);
        dwell(4'b1101, 7'h12, 32);
        dwell(4'b1011, 7'h06, 32);
        chg = cyc;
        dwell(4'b0111, 7'h4C, 32);
        chk("asm_pulses", fv_cnt - f0, 1);
        chk("asm_latency", last_fv_cyc - chg, 19);

        push_frame(16'h4321, 4'b0000);
        dwell(4'b1110, 7'h4F, 32);
        dwell(4'b1101, 7'h12, 32);
        dwell(4'b1011, 7'h06, 25);
        dwell(4'b1011, 7'h00, 5);
        dwell(4'b1011, 7'h06, 10);
        dwell(4'b0111, 7'h4C, 32);

        push_frame(16'h4301, 4'b0010);
        dwell(4'b1110, 7'h4F, 20);
        dwell(4'b1101, 7'h7F, 20);
        dwell(4'b1011, 7'h06, 20);
        dwell(4'b0111, 7'h4C, 20);

        // A multi-low anode must not mark digits 0/1 as seen.
        push_err();
        push_frame(16'h4321, 4'b0000);
        dwell(4'b1100, 7'h4F, 20);
        dwell(4'b1011, 7'h06, 20);
        dwell(4'b0111, 7'h4C, 20);
        dwell(4'b1110, 7'h4F, 20);
        dwell(4'b1101, 7'h12, 20);

        push_err();
        bus.AN  = 4'b1111;
        bus.SEG = 7'h7F;
        for (int k = 0; k < 200 && cyc < last_fv_cyc + 63; k++) @(negedge clk);
        chk("stale_wait", cyc - last_fv_cyc, 63);
        chk("stale_before_64", bus.STALE, 0);
        @(negedge clk);
        chk("stale_at_64", bus.STALE, 1);
        @(posedge clk);
        #1;
        dwell(4'b1111, 7'h7F, 30);
        chk("stale_held", bus.STALE, 1);
        push_frame(16'h4321, 4'b0000);
        dwell(4'b1110, 7'h4F, 20);
        dwell(4'b1101, 7'h12, 20);
        dwell(4'b1011, 7'h06, 20);
        dwell(4'b0111, 7'h4C, 20);
        chk("stale_cleared", bus.STALE, 0);

        dwell(4'b1110, 7'h4F, 20);
        dwell(4'b1101, 7'h12, 20);
        dwell(4'b1011, 7'h06, 20);
        dwell(4'b0111, 7'h4C, 5);
        rst_n = 1'b0;
        #1;
        outs_zero("async_reset_outputs");
        chk("queue_before_reset", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = fv_cnt;
        push_frame(16'h76E8, 4'b0000);
        dwell(4'b1110, 7'h00, 20);
        dwell(4'b1101, 7'h30, 20);
        dwell(4'b1011, 7'h20, 20);
        dwell(4'b0111, 7'h0F, 30);
        chk("post_reset_pulses", fv_cnt - f0, 1);
        chk("post_reset_digits", bus.DIGITS, 16'h76E8);

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
